// File: rtl/load_store_unit.sv
// Load/store adapter between the MEM stage and a word-only data memory:
// lane extraction with sign/zero extension, read-modify-write for sub-word stores.
module load_store_unit #(
   parameter logic [31:0] ADDR_LIMIT = 32'h0000_0400
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_unsigned,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wd,
   output logic        mem_we,
   input  logic [31:0] mem_rd
);

   typedef enum logic [2:0] {IDLE, ACCESS, RMW_RD, RMW_WR, ERR} state_t;

   state_t      state_q, state_d;
   logic        we_q, we_d;
   logic [1:0]  size_q, size_d;
   logic        uns_q, uns_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] addr_q, addr_d;
   logic [1:0]  lane_q, lane_d;
   logic [31:0] merge_q, merge_d;
   logic        resp_valid_q, resp_valid_d;
   logic        resp_err_q, resp_err_d;
   logic [31:0] resp_rdata_q, resp_rdata_d;
   logic        mem_we_q, mem_we_d;
   logic [31:0] mem_wd_q, mem_wd_d;

   logic [31:0] aligned;
   logic        req_err;
   logic [4:0]  byte_sh, half_sh;
   logic [31:0] byte_rd, half_rd, load_data, merged, lane_mask, lane_data;

   assign aligned = {req_addr[31:2], 2'b00};
   assign req_err = (req_size == 2'b11)
                  || (req_size == 2'b01 && req_addr[0])
                  || (req_size == 2'b10 && req_addr[1:0] != 2'b00)
                  || (aligned >= ADDR_LIMIT);

   assign byte_sh = {lane_q, 3'b000};
   assign half_sh = {lane_q[1], 4'b0000};
   assign byte_rd = mem_rd >> byte_sh;
   assign half_rd = mem_rd >> half_sh;

   always_comb begin
      load_data = mem_rd;
      lane_mask = 32'h0000_FFFF << half_sh;
      lane_data = {16'h0000, wdata_q[15:0]} << half_sh;
      case (size_q)
         2'b00:   load_data = uns_q ? {24'h0, byte_rd[7:0]} : {{24{byte_rd[7]}}, byte_rd[7:0]};
         2'b01:   load_data = uns_q ? {16'h0, half_rd[15:0]} : {{16{half_rd[15]}}, half_rd[15:0]};
         default: load_data = mem_rd;
      endcase
      if (size_q == 2'b00) begin
         lane_mask = 32'h0000_00FF << byte_sh;
         lane_data = {24'h0, wdata_q[7:0]} << byte_sh;
      end
      merged = (mem_rd & ~lane_mask) | lane_data;
   end

   always_comb begin
      state_d      = state_q;
      we_d         = we_q;
      size_d       = size_q;
      uns_d        = uns_q;
      wdata_d      = wdata_q;
      addr_d       = addr_q;
      lane_d       = lane_q;
      merge_d      = merge_q;
      resp_valid_d = 1'b0;
      resp_err_d   = 1'b0;
      resp_rdata_d = '0;
      mem_we_d     = 1'b0;
      mem_wd_d     = '0;
      case (state_q)
         IDLE: if (req_valid) begin
            we_d    = req_we;
            size_d  = req_size;
            uns_d   = req_unsigned;
            wdata_d = req_wdata;
            addr_d  = aligned;
            lane_d  = req_addr[1:0];
            if (req_err) begin
               state_d = ERR;
            end else if (req_we && req_size != 2'b10) begin
               state_d = RMW_RD;
            end else begin
               state_d = ACCESS;
               // Write strobe is registered, so it is raised here to cover the ACCESS cycle.
               if (req_we) begin
                  mem_we_d = 1'b1;
                  mem_wd_d = req_wdata;
               end
            end
         end
         ACCESS: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            if (!we_q) resp_rdata_d = load_data;
         end
         RMW_RD: begin
            state_d  = RMW_WR;
            merge_d  = merged;
            mem_we_d = 1'b1;
            mem_wd_d = merged;
         end
         RMW_WR: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
         end
         ERR: begin
            state_d      = IDLE;
            resp_valid_d = 1'b1;
            resp_err_d   = 1'b1;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         we_q         <= 1'b0;
         size_q       <= 2'b00;
         uns_q        <= 1'b0;
         wdata_q      <= '0;
         addr_q       <= '0;
         lane_q       <= 2'b00;
         merge_q      <= '0;
         resp_valid_q <= 1'b0;
         resp_err_q   <= 1'b0;
         resp_rdata_q <= '0;
         mem_we_q     <= 1'b0;
         mem_wd_q     <= '0;
      end else begin
         state_q      <= state_d;
         we_q         <= we_d;
         size_q       <= size_d;
         uns_q        <= uns_d;
         wdata_q      <= wdata_d;
         addr_q       <= addr_d;
         lane_q       <= lane_d;
         merge_q      <= merge_d;
         resp_valid_q <= resp_valid_d;
         resp_err_q   <= resp_err_d;
         resp_rdata_q <= resp_rdata_d;
         mem_we_q     <= mem_we_d;
         mem_wd_q     <= mem_wd_d;
      end
   end

   assign req_ready  = (state_q == IDLE);
   assign resp_valid = resp_valid_q;
   assign resp_err   = resp_err_q;
   assign resp_rdata = resp_rdata_q;
   assign mem_addr   = addr_q;
   assign mem_we     = mem_we_q;
   assign mem_wd     = mem_wd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit with a negedge-write word memory model.
module tb_load_store_unit;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_unsigned = 1'b0;
   logic [31:0] req_addr = '0;
   logic [31:0] req_wdata = '0;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] mem_addr;
   logic [31:0] mem_wd;
   logic        mem_we;
   logic [31:0] mem_rd;

   int checks = 0;
   int errors = 0;
   int write_cnt = 0;

   logic [31:0] mem [0:255];

   load_store_unit #(.ADDR_LIMIT(32'h0000_0400)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
      .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
      .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
      .resp_err(resp_err), .mem_addr(mem_addr), .mem_wd(mem_wd),
      .mem_we(mem_we), .mem_rd(mem_rd)
   );

   always #5 clk = ~clk;

   assign mem_rd = mem[mem_addr[9:2]];

   always @(negedge clk) begin
      if (mem_we) begin
         mem[mem_addr[9:2]] <= mem_wd;
         write_cnt <= write_cnt + 1;
      end
   end

   // Issues one request and follows it until its response (bounded to 20 edges).
   task automatic do_req(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         output logic got, output logic [31:0] rdata, output logic err,
                         output int edges, output int we_cyc, output logic one_cycle);
      @(negedge clk);
      req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
      req_addr = addr; req_wdata = wdata;
      @(posedge clk); #1;
      req_valid = 1'b0;
      edges = 1; we_cyc = 0; got = 1'b0; rdata = '0; err = 1'b0; one_cycle = 1'b0;
      while (!got && edges < 20) begin
         if (mem_we) we_cyc++;
         if (resp_valid) begin
            got = 1'b1; rdata = resp_rdata; err = resp_err;
         end else begin
            @(posedge clk); #1;
            edges++;
         end
      end
      if (got) begin
         @(posedge clk); #1;
         one_cycle = !resp_valid;
      end
   endtask

   task automatic test_reset();
      @(negedge clk);
      req_valid = 1'b1; req_addr = 32'h10; req_size = 2'b10;
      @(posedge clk); #1;
      checks++;
      if (req_ready !== 1'b1 || resp_valid !== 1'b0 || mem_we !== 1'b0 || resp_err !== 1'b0) begin
         errors++;
         $display("FAIL reset_ctrl: ready=%b valid=%b we=%b err=%b required 1 0 0 0",
                  req_ready, resp_valid, mem_we, resp_err);
      end
      checks++;
      if (mem_addr !== 32'h0 || mem_wd !== 32'h0 || resp_rdata !== 32'h0) begin
         errors++;
         $display("FAIL reset_data: addr=%h wd=%h rdata=%h required all 0", mem_addr, mem_wd, resp_rdata);
      end
      req_valid = 1'b0;
      rst_n = 1'b1;
      @(posedge clk); #1;
      checks++;
      if (mem_addr !== 32'h0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL reset_no_accept: addr=%h ready=%b required 0 1", mem_addr, req_ready);
      end
   endtask

   task automatic test_loads();
      logic [1:0]  sz [5];
      logic        un [5];
      logic [31:0] ad [5];
      logic [31:0] ex [5];
      logic got, err, one;
      logic [31:0] rd;
      int edges, wc;
      sz = '{2'b10, 2'b00, 2'b00, 2'b01, 2'b01};
      un = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
      ad = '{32'h10, 32'h13, 32'h13, 32'h12, 32'h10};
      ex = '{32'h8899AABB, 32'hFFFFFF88, 32'h00000088, 32'hFFFF8899, 32'h0000AABB};
      for (int i = 0; i < 5; i++) begin
         do_req(1'b0, sz[i], un[i], ad[i], 32'h0, got, rd, err, edges, wc, one);
         checks++;
         if (!got || rd !== ex[i] || err !== 1'b0) begin
            errors++;
            $display("FAIL load_%0d: got=%b rdata=%h err=%b required 1 %h 0", i, got, rd, err, ex[i]);
         end
         checks++;
         if (edges != 2 || !one || wc != 0) begin
            errors++;
            $display("FAIL load_timing_%0d: edges=%0d one_cycle=%b we_cycles=%0d required 2 1 0", i, edges, one, wc);
         end
      end
      do_req(1'b0, 2'b10, 1'b0, 32'h3FC, 32'h0, got, rd, err, edges, wc, one);
      checks++;
      if (!got || rd !== 32'h01020304 || err !== 1'b0) begin
         errors++;
         $display("FAIL load_limit_edge: rdata=%h err=%b required 01020304 0", rd, err);
      end
   endtask

   task automatic test_stores();
      logic got, err, one;
      logic [31:0] rd;
      int edges, wc, w0;
      w0 = write_cnt;
      do_req(1'b1, 2'b00, 1'b0, 32'h11, 32'h12345677, got, rd, err, edges, wc, one);
      checks++;
      if (mem[4] !== 32'h889977BB || write_cnt - w0 != 1) begin
         errors++;
         $display("FAIL sb_data: mem=%h writes=%0d required 889977bb 1", mem[4], write_cnt - w0);
      end
      checks++;
      if (!got || edges != 3 || wc != 1 || !one || err !== 1'b0 || rd !== 32'h0) begin
         errors++;
         $display("FAIL sb_timing: got=%b edges=%0d we_cycles=%0d one=%b err=%b rdata=%h required 1 3 1 1 0 0",
                  got, edges, wc, one, err, rd);
      end
      do_req(1'b1, 2'b01, 1'b0, 32'h12, 32'hCAFE1234, got, rd, err, edges, wc, one);
      checks++;
      if (mem[4] !== 32'h123477BB || edges != 3) begin
         errors++;
         $display("FAIL sh_data: mem=%h edges=%0d required 123477bb 3", mem[4], edges);
      end
      w0 = write_cnt;
      do_req(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, got, rd, err, edges, wc, one);
      checks++;
      if (mem[4] !== 32'hDEADBEEF || edges != 2 || wc != 1 || write_cnt - w0 != 1) begin
         errors++;
         $display("FAIL sw: mem=%h edges=%0d we_cycles=%0d writes=%0d required deadbeef 2 1 1",
                  mem[4], edges, wc, write_cnt - w0);
      end
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, rd, err, edges, wc, one);
      checks++;
      if (rd !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL sw_readback: rdata=%h required deadbeef", rd);
      end
   endtask

   task automatic test_errors();
      logic        we [4];
      logic [1:0]  sz [4];
      logic [31:0] ad [4];
      logic got, err, one;
      logic [31:0] rd;
      int edges, wc, w0;
      we = '{1'b1, 1'b1, 1'b0, 1'b0};
      sz = '{2'b01, 2'b10, 2'b10, 2'b11};
      ad = '{32'h11, 32'h402, 32'h400, 32'h10};
      for (int i = 0; i < 4; i++) begin
         w0 = write_cnt;
         do_req(we[i], sz[i], 1'b0, ad[i], 32'h5555AAAA, got, rd, err, edges, wc, one);
         checks++;
         if (!got || err !== 1'b1 || rd !== 32'h0 || edges != 2 || !one) begin
            errors++;
            $display("FAIL err_%0d: got=%b err=%b rdata=%h edges=%0d one=%b required 1 1 0 2 1",
                     i, got, err, rd, edges, one);
         end
         checks++;
         if (wc != 0 || write_cnt != w0 || mem[4] !== 32'hDEADBEEF || mem[0] !== 32'h0) begin
            errors++;
            $display("FAIL err_mem_%0d: we_cycles=%0d writes=%0d mem10=%h mem0=%h required 0 0 deadbeef 0",
                     i, wc, write_cnt - w0, mem[4], mem[0]);
         end
      end
   endtask

   task automatic test_back_to_back();
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_unsigned = 1'b0; req_addr = 32'h10;
      @(posedge clk); #1;
      req_size = 2'b00; req_unsigned = 1'b1; req_addr = 32'h13;
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || req_ready !== 1'b1 || resp_rdata !== 32'hDEADBEEF) begin
         errors++;
         $display("FAIL b2b_first: valid=%b ready=%b rdata=%h required 1 1 deadbeef", resp_valid, req_ready, resp_rdata);
      end
      @(posedge clk); #1;
      req_valid = 1'b0;
      checks++;
      if (resp_valid !== 1'b0 || req_ready !== 1'b0) begin
         errors++;
         $display("FAIL b2b_accept: valid=%b ready=%b required 0 0", resp_valid, req_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (resp_valid !== 1'b1 || resp_rdata !== 32'h000000DE) begin
         errors++;
         $display("FAIL b2b_second: valid=%b rdata=%h required 1 000000de", resp_valid, resp_rdata);
      end
   endtask

   task automatic test_reset_abort();
      logic got, err, one;
      logic [31:0] rd;
      int edges, wc, w0, seen;
      w0 = write_cnt;
      seen = 0;
      @(negedge clk);
      req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_addr = 32'h10; req_wdata = 32'h55;
      @(posedge clk); #1;
      req_valid = 1'b0;
      @(posedge clk); #1;
      checks++;
      if (mem_we !== 1'b1) begin
         errors++;
         $display("FAIL abort_rmw_wr: mem_we=%b required 1", mem_we);
      end
      #1 rst_n = 1'b0;
      #1;
      checks++;
      if (mem_we !== 1'b0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_async: mem_we=%b ready=%b required 0 1", mem_we, req_ready);
      end
      @(posedge clk); #2;
      rst_n = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         if (resp_valid) seen++;
      end
      checks++;
      if (seen != 0 || mem[4] !== 32'hDEADBEEF || write_cnt != w0 || req_ready !== 1'b1) begin
         errors++;
         $display("FAIL abort_effect: resp=%0d mem=%h writes=%0d ready=%b required 0 deadbeef 0 1",
                  seen, mem[4], write_cnt - w0, req_ready);
      end
      do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, got, rd, err, edges, wc, one);
      checks++;
      if (!got || rd !== 32'hDEADBEEF || err !== 1'b0) begin
         errors++;
         $display("FAIL abort_readback: got=%b rdata=%h err=%b required 1 deadbeef 0", got, rd, err);
      end
   endtask

   initial begin
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[4]   = 32'h8899AABB;
      mem[255] = 32'h01020304;
      test_reset();
      test_loads();
      test_stores();
      test_errors();
      test_back_to_back();
      test_reset_abort();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Sits between the pipeline MEM stage and `data_mem`; converts byte/halfword/word load and store requests into word-aligned accesses on `data_mem`'s port. Loads get little-endian lane extraction with sign/zero extension. Sub-word stores are performed as a read-modify-write, because `data_mem` only writes whole words. Misaligned, out-of-range and reserved-size requests complete with an error and never touch memory.

## Interface
Parameters:
- `ADDR_LIMIT`, default `32'h0000_0400`: first invalid byte address. Must be a multiple of 4 and ≤ `DATA_NUM`+1.

Ports:
- `clk`  in  1  clock. Posedge logic; `data_mem` writes on negedge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept; `req_ready` = (state == IDLE).
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 reserved.
- `req_unsigned`  in  1  zero-extend a sub-word load; ignored for word accesses and stores.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, LSB-justified.
- `resp_valid`  out  1  one-cycle completion pulse.
- `resp_rdata`  out  32  load result; 0 for stores and errors.
- `resp_err`  out  1  error flag, qualified by `resp_valid`.
- `mem_addr`  out  32  word-aligned address to `data_mem`.
- `mem_wd`  out  32  write data to `data_mem`.
- `mem_we`  out  1  write enable to `data_mem`.
- `mem_rd`  in  32  combinational read data from `data_mem`.

## Operation
- A request is accepted on a posedge with `req_valid & req_ready`. At acceptance the unit registers:
  - `req_we`, `req_size`, `req_unsigned` and `req_wdata`;
  - the aligned address `{req_addr[31:2],2'b00}`;
  - the byte lane `req_addr[1:0]`.
- An error is detected at acceptance if any of these hold:
  - `req_size` == 11;
  - halfword access with `addr[0]`=1;
  - word access with `addr[1:0]`≠0;
  - aligned address ≥ `ADDR_LIMIT`.
- States:
  - IDLE: `req_ready`=1.
    - Error request → ERR.
    - Load or word store → ACCESS.
    - Byte or half store → RMW_RD.
  - ACCESS:
    - Load: `mem_we`=0; `resp_rdata` is loaded from `mem_rd`.
    - Word store: `mem_we`=1, `mem_wd`=`req_wdata`.
    - Next state: IDLE, with `resp_valid` set.
  - RMW_RD: `mem_we`=0; a merge register loads `mem_rd` with the target lane(s) replaced. Next state: RMW_WR.
    - Byte: `wdata[7:0]` replaces byte `lane`.
    - Half: `wdata[15:0]` replaces half `lane[1]`.
  - RMW_WR: `mem_we`=1, `mem_wd`=merge register. Next state: IDLE, with `resp_valid` set.
  - ERR: no memory activity. Next state: IDLE, with `resp_valid`=1, `resp_err`=1, `resp_rdata`=0.
- Load extraction:
  - byte = `mem_rd[8*lane +: 8]`;
  - half = `mem_rd[16*lane[1] +: 16]`;
  - sign-extend the selected bits unless `req_unsigned`.
- Outputs outside the states that drive them:
  - `mem_we` is 0 in IDLE, ERR and RMW_RD.
  - `mem_wd` is 0 except in write cycles.
  - `mem_addr` holds the registered aligned address in all states.

## Timing
- Reset values:
  - state IDLE;
  - `resp_valid`, `resp_err` = 0;
  - `resp_rdata`, `mem_addr`, `mem_wd`, merge register = 0;
  - `mem_we` = 0;
  - `req_ready` = 1 once the state is IDLE. No request is accepted while `rst_n` is low.
- Latency, counted from the acceptance edge E0 to the cycle in which `resp_valid` is high:
  - loads, word stores, errors: `resp_valid` is high after E1 (2 edges including E0);
  - sub-word stores: high after E2.
- `resp_valid` is high for exactly one cycle. `req_ready` is 1 in that same cycle, so a new request may be accepted concurrently with the response. Peak throughput is one request per 2 cycles.
- `mem_we` is high for exactly one full clock cycle per store. The `data_mem` negedge falls inside that cycle, so exactly one write occurs.
- Reset mid-operation:
  - The state returns to IDLE immediately and asynchronously; `mem_we` drops at once.
  - A store whose negedge has not yet occurred is not written.
  - No response is produced for the aborted request.

## Test plan
Preload: word 0x10 = 0x8899AABB (byte 0x10=BB, 0x13=88).
- Word load: lw 0x10 → `resp_rdata`=0x8899AABB, `resp_err`=0; `resp_valid` high for one cycle, 2 edges after acceptance.
- Sub-word loads:
  - lb 0x13 → 0xFFFFFF88;
  - lbu 0x13 → 0x00000088;
  - lh 0x12 → 0xFFFF8899;
  - lhu 0x10 → 0x0000AABB.
- Byte store: sb 0x11 with wdata 0x12345677 → word 0x10 = 0x889977BB.
  - `mem_we` high for exactly one cycle, in RMW_WR;
  - `resp_valid` 3 edges after acceptance;
  - then sw 0x10 with 0xDEADBEEF → lw returns 0xDEADBEEF.
- Errors: sh 0x11, sw 0x402, lw 0x400, and size 11 → each gives `resp_err`=1, `resp_rdata`=0, `mem_we` never high, memory unchanged.
- Back-to-back: a second lw presented in the cycle `resp_valid` is high → accepted in that cycle; its response follows 2 cycles later.
- Reset abort: sb 0x10 issued, `rst_n` pulled low during RMW_WR before the negedge.
  - Word 0x10 is unchanged and no `resp_valid` is produced.
  - `req_ready`=1 after release; the next lw 0x10 returns the original value.
